// File: rtl/mul_seq_if.sv
// Operand/result bundle for mul_seq; the sgn field exists only when MUL_SIGNED_EN is defined.
interface mul_seq_if #(
  parameter int W = 8
);
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
`ifdef MUL_SIGNED_EN
  logic           sgn;
`endif
  logic           busy;
  logic           done;
  logic [2*W-1:0] z;

`ifdef MUL_SIGNED_EN
  modport master (output start, a, b, sgn, input busy, done, z);
  modport slave  (input start, a, b, sgn, output busy, done, z);
`else
  modport master (output start, a, b, input busy, done, z);
  modport slave  (input start, a, b, output busy, done, z);
`endif
endinterface

// File: rtl/mul_seq.sv
// Radix-2 shift-add multiplier, W cycles from start sample to done, next issue accepted in the done cycle.
// Signed operands are supported when MUL_SIGNED_EN is defined (sign-magnitude around an unsigned core).
module mul_seq #(
  parameter int W = 8
) (
  input  logic    clk,
  input  logic    rst,
  mul_seq_if.slave bus
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] z_q, z_d;
  logic           sign_q, sign_d;

  logic [W-1:0]   a_mag, b_mag;
  logic           sign_in;
  logic [W:0]     sum;
  logic [2*W-1:0] prod_next;

`ifdef MUL_SIGNED_EN
  // Magnitudes stay W-bit unsigned so -2^(W-1) converts without overflow.
  always_comb begin
    a_mag   = (bus.sgn && bus.a[W-1]) ? -bus.a : bus.a;
    b_mag   = (bus.sgn && bus.b[W-1]) ? -bus.b : bus.b;
    sign_in = bus.sgn & (bus.a[W-1] ^ bus.b[W-1]);
  end
`else
  always_comb begin
    a_mag   = bus.a;
    b_mag   = bus.b;
    sign_in = 1'b0;
  end
`endif

  // lo holds the unconsumed multiplier bits; product bits shift in from the top.
  assign sum       = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
  assign prod_next = {sum, lo_q[W-1:1]};

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    sign_d  = sign_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          mcand_d = a_mag;
          lo_d    = b_mag;
          hi_d    = '0;
          cnt_d   = '0;
          sign_d  = sign_in;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        {hi_d, lo_d} = prod_next;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          z_d     = sign_q ? -prod_next : prod_next;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      sign_q  <= sign_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.z    = z_q;
endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq at W=4, 8 and 6; signed vectors run when MUL_SIGNED_EN is defined.
module tb_mul_seq;
  logic clk = 1'b0;
  logic rst;
  logic last_sg;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mul_seq_if #(.W(4)) if4 ();
  mul_seq_if #(.W(8)) if8 ();
  mul_seq_if #(.W(6)) if6 ();

  mul_seq #(.W(4)) u4 (.clk(clk), .rst(rst), .bus(if4));
  mul_seq #(.W(8)) u8 (.clk(clk), .rst(rst), .bus(if8));
  mul_seq #(.W(6)) u6 (.clk(clk), .rst(rst), .bus(if6));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic [31:0] av, input logic [31:0] bv,
                       input logic sg);
    last_sg = sg;
    case (w)
      4: begin
        if4.start = st; if4.a = av[3:0]; if4.b = bv[3:0];
`ifdef MUL_SIGNED_EN
        if4.sgn = sg;
`endif
      end
      8: begin
        if8.start = st; if8.a = av[7:0]; if8.b = bv[7:0];
`ifdef MUL_SIGNED_EN
        if8.sgn = sg;
`endif
      end
      default: begin
        if6.start = st; if6.a = av[5:0]; if6.b = bv[5:0];
`ifdef MUL_SIGNED_EN
        if6.sgn = sg;
`endif
      end
    endcase
  endtask

  function automatic void get(input int w, output logic bsy, output logic dn, output logic [63:0] zv);
    case (w)
      4:       begin bsy = if4.busy; dn = if4.done; zv = 64'(if4.z); end
      8:       begin bsy = if8.busy; dn = if8.done; zv = 64'(if8.z); end
      default: begin bsy = if6.busy; dn = if6.done; zv = 64'(if6.z); end
    endcase
  endfunction

  // Issue one product; lat counts edges from the start-sampling edge to the done cycle.
  task automatic issue(input int w, input logic [31:0] av, input logic [31:0] bv, input logic sg,
                       output int lat, output int nb, output logic [63:0] zv);
    logic bsy, dn;
    @(negedge clk);
    drive(w, 1'b1, av, bv, sg);
    @(negedge clk);
    drive(w, 1'b0, ~av, ~bv, ~sg);
    get(w, bsy, dn, zv);
    nb  = bsy ? 1 : 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      get(w, bsy, dn, zv);
      if (bsy) nb++;
      chk("busy_done_overlap", {63'd0, bsy & dn}, 64'd0);
    end while (!dn && lat < 40);
  endtask

  initial begin
    int          lat, nb, d1, d2, ndone;
    logic [63:0] zv, z1, z2, expv;
    logic        bsy, dn;
    logic [31:0] av, bv;
    logic        sg;
    longint      sa, sb;

    rst = 1'b1;
    drive(4, 1'b0, 0, 0, 1'b0);
    drive(8, 1'b0, 0, 0, 1'b0);
    drive(6, 1'b0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    get(8, bsy, dn, zv);
    chk("reset_busy", {63'd0, bsy}, 64'd0);
    chk("reset_done", {63'd0, dn}, 64'd0);
    chk("reset_z", zv, 64'd0);
    rst = 1'b0;

    // W=4 maximum operands
    issue(4, 15, 15, 1'b0, lat, nb, zv);
    chk("w4_latency", 64'(lat), 64'd4);
    chk("w4_busy_cycles", 64'(nb), 64'd4);
    chk("w4_z", zv, 64'd225);
    @(negedge clk);
    get(4, bsy, dn, zv);
    chk("w4_done_one_cycle", {63'd0, dn}, 64'd0);
    repeat (10) @(negedge clk);
    get(4, bsy, dn, zv);
    chk("w4_z_hold", zv, 64'd225);

    // zero multiplicand still runs all W steps
    issue(8, 0, 200, 1'b0, lat, nb, zv);
    chk("w8_zero_latency", 64'(lat), 64'd8);
    chk("w8_zero_z", zv, 64'd0);

    // start held high: back-to-back issue from the done cycle
    @(negedge clk);
    drive(8, 1'b1, 3, 5, 1'b0);
    @(negedge clk);
    d1 = -1; d2 = -1; z1 = '0; z2 = '0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge clk);
      get(8, bsy, dn, zv);
      chk("held_overlap", {63'd0, bsy & dn}, 64'd0);
      if (dn && d1 < 0) begin
        d1 = i; z1 = zv; drive(8, 1'b1, 7, 9, 1'b0);
      end else if (dn && d2 < 0) begin
        d2 = i; z2 = zv; drive(8, 1'b0, 0, 0, 1'b0);
      end
    end
    chk("held_first_done", 64'(d1), 64'd8);
    chk("held_interval", 64'(d2 - d1), 64'd9);
    chk("held_z1", z1, 64'd15);
    chk("held_z2", z2, 64'd63);

    // asynchronous reset in the third RUN cycle
    @(negedge clk);
    drive(8, 1'b1, 200, 100, 1'b0);
    @(negedge clk);
    drive(8, 1'b0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    get(8, bsy, dn, zv);
    chk("midrun_rst_busy", {63'd0, bsy}, 64'd0);
    chk("midrun_rst_done", {63'd0, dn}, 64'd0);
    chk("midrun_rst_z", zv, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      get(8, bsy, dn, zv);
      if (dn) ndone++;
    end
    chk("no_done_after_rst", 64'(ndone), 64'd0);
    issue(8, 12, 12, 1'b0, lat, nb, zv);
    chk("after_rst_latency", 64'(lat), 64'd8);
    chk("after_rst_z", zv, 64'd144);

`ifdef MUL_SIGNED_EN
    issue(4, 32'h8, 32'h8, 1'b1, lat, nb, zv);
    chk("s_neg8_neg8", zv, 64'h40);
    issue(4, 32'hD, 32'h5, 1'b1, lat, nb, zv);
    chk("s_neg3_5", zv, 64'hF1);
    issue(4, 32'h7, 32'hF, 1'b1, lat, nb, zv);
    chk("s_7_neg1", zv, 64'hF9);
    issue(4, 32'hF, 32'hF, 1'b0, lat, nb, zv);
    chk("s_unsigned_mode", zv, 64'd225);
`endif

    // W=6 random sweep against a behavioural product
    for (int k = 0; k < 500; k++) begin
      av = $urandom_range(0, 63);
      bv = $urandom_range(0, 63);
`ifdef MUL_SIGNED_EN
      sg = 1'($urandom_range(0, 1));
`else
      sg = 1'b0;
`endif
      sa = longint'(av) - ((sg && av[5]) ? 64 : 0);
      sb = longint'(bv) - ((sg && bv[5]) ? 64 : 0);
      expv = 64'(sa * sb) & 64'hFFF;
      issue(6, av, bv, sg, lat, nb, zv);
      chk("rand_latency", 64'(lat), 64'd6);
      chk("rand_z", zv, expv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mul_seq.md
# mul_seq

Sequential shift-add multiplier, parametrised in operand width. It is the multi-cycle successor to the team's combinational 4-bit multiplier. It trades W cycles of latency for one W-bit adder, and adds a start/busy/done handshake plus optional signed mode. It sits behind a register-interfaced datapath, and a controller issues one product at a time.

## Interface
- W, default 8: operand width in bits, legal range 2..32; the product is 2W bits.
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled on the rising edge of clk.
- a  input  W  multiplicand; sampled with start.
- b  input  W  multiplier; sampled with start.
- sgn  input  1  1 = two's-complement operands; sampled with start. The port exists only when MUL_SIGNED_EN is defined.
- busy  output  1  high while a multiplication is in progress.
- done  output  1  single-cycle pulse; z is valid from this cycle.
- z  output  2W  product; holds its value until the next completion.

## Operation
- One clock (clk). Reset is asynchronous and active-high (rst).
- FSM states:
  - IDLE: busy=0, done=0. With start=1, capture a, b (and sgn), clear the accumulator, counter=0, go to RUN.
  - RUN: busy=1. Each edge does one radix-2 step. If the multiplier LSB is 1, add the multiplicand to the upper half of the accumulator with carry out. Then shift the accumulator {carry, acc} right by 1. Counter increments each step. After the step with counter=W-1, load z and go to DONE.
  - DONE: done=1, busy=0, lasts exactly one cycle. With start=1, capture new operands and go to RUN (back-to-back issue). Otherwise go to IDLE.
- start in RUN is ignored. The operands are not re-sampled, and no error is flagged.
- The a and b inputs may change freely after the capture edge. Only the captured copies are used.
- Unsigned arithmetic: z = a*b exactly, with no truncation. The maximum is (2^W-1)^2, which fits in 2W bits.
- Internal adder width is W+1 bits, so the carry is never lost.
- A zero operand still takes the full W cycles; there is no early termination.
- On reset:
  - State goes to IDLE.
  - busy=0, done=0, z=0, counter=0, accumulator=0.
  - This applies immediately, including mid-RUN. The in-flight product is discarded, and no done is produced for it.
- start asserted in the same cycle that rst deasserts is sampled normally on the next edge.

## Timing
- Let E0 be the edge where start=1 is sampled in IDLE or DONE.
- busy rises after E0 and stays high for W cycles.
- z is updated and done=1 after edge E_W, for one cycle.
- Latency from start-sample to done is W clock cycles.
- Minimum issue interval is W+1 cycles. Issuing start during the done cycle achieves it.
- z changes only at the edge that enters DONE, or at reset. It is stable between completions.
- busy and done are never high in the same cycle.

## Configuration
- The macro MUL_SIGNED_EN controls signed support.
- Defined, capture behaviour:
  - The sgn port exists.
  - With sgn=1, the captured a and b are converted to magnitudes at capture, and the sign s = a[W-1]^b[W-1] is stored.
  - The unsigned core runs unchanged.
- Defined, load behaviour: at the load into DONE, z = s ? -P : P, with 2W-bit two's-complement negation.
- Defined, edge case: -2^(W-1) * -2^(W-1) = 2^(2W-2) must come out exactly. This is why the magnitude path is W bits unsigned.
- Defined, unsigned mode: with sgn=0, behaviour is identical to the unsigned build.
- Not defined: no sgn port, no conversion logic, and all operands are unsigned.

## Test plan
- W=4, a=15, b=15, one start pulse -> busy for 4 cycles, done pulses once, z=225. z still reads 225 ten cycles later.
- W=8, a=0, b=200 -> done arrives after exactly 8 cycles with z=0. There is no early finish.
- W=8, start held high continuously with a=3,b=5 then a=7,b=9 presented at each DONE cycle -> z=15 then z=63, done every 9 cycles. start in RUN is ignored, and busy never overlaps done.
- W=8, rst pulsed at cycle 3 of RUN, asynchronous mid-cycle -> busy, done and z read 0 immediately. No done follows, and a subsequent 12*12 yields z=144.
- MUL_SIGNED_EN, W=4, sgn=1 -> expected results:
  - a=-8, b=-8 gives z=64.
  - a=-3, b=5 gives z=8'hF1 (-15).
  - a=7, b=-1 gives z=8'hF9.
  - sgn=0 with a=4'hF, b=4'hF gives z=225.
- W=6, 500 random a, b (and sgn when enabled) -> every z matches the behavioural product computed in the bench, with latency exactly 6 cycles.
